// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
//   Bus bundle between the pipeline (decode + writeback) and the register
//   file with busy scoreboard.
//
//   Signals (direction seen from the register file, i.e. the slave side):
//     ctrl_writeEnable  in   write strobe from writeback
//     ctrl_writeReg     in   write address
//     data_writeReg     in   write data
//     ctrl_readReg      in   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//     data_readReg      out  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//     read_busy         out  per-port "addressed register has a pending write"
//     ctrl_markBusy     in   mark ctrl_busyReg as owned by an in-flight op
//     ctrl_busyReg      in   register to mark busy
//     busy_count        out  number of registers currently busy
//
//   master: the pipeline side driving requests.
//   slave:  the register file.
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_READ   = 2
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic                           ctrl_writeEnable;
  logic [ADDR_W-1:0]              ctrl_writeReg;
  logic [DATA_WIDTH-1:0]          data_writeReg;
  logic [NUM_READ*ADDR_W-1:0]     ctrl_readReg;
  logic [NUM_READ*DATA_WIDTH-1:0] data_readReg;
  logic [NUM_READ-1:0]            read_busy;
  logic                           ctrl_markBusy;
  logic [ADDR_W-1:0]              ctrl_busyReg;
  logic [ADDR_W:0]                busy_count;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readReg,
    output ctrl_markBusy,
    output ctrl_busyReg,
    input  data_readReg,
    input  read_busy,
    input  busy_count
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readReg,
    input  ctrl_markBusy,
    input  ctrl_busyReg,
    output data_readReg,
    output read_busy,
    output busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   NUM_REGS x DATA_WIDTH register file with NUM_READ combinational read
//   ports, one write port, register 0 hardwired to zero, optional
//   write-to-read bypass and a per-register busy scoreboard used by decode
//   to stall on registers owned by in-flight multi-cycle operations.
//
//   Ports:
//     clock       sole clock, rising edge
//     ctrl_reset  asynchronous active-low reset; clears data, busy bits and
//                 the busy counter, and forces all read data to zero while low
//     bus         regfile_sb_if.slave bundle (reads, write, busy marking)
//
//   Parameters:
//     DATA_WIDTH  register width
//     NUM_REGS    register count (power of two, >= 2)
//     NUM_READ    number of read ports (>= 1)
//     BYPASS      1: same-cycle write data/clear forwarded to matching reads
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  regfile_sb_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  // Register 0 has no storage; arrays start at index 1.
  logic [DATA_WIDTH-1:0] regs_reg  [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_next [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]   busy_reg;
  logic [NUM_REGS-1:1]   busy_next;
  logic [ADDR_W:0]       busy_count_reg;
  logic [ADDR_W:0]       busy_count_next;

  // Full-range views with entry 0 tied to zero, so lookups by address need
  // no special case for register 0.
  logic [DATA_WIDTH-1:0] rd_view [0:NUM_REGS-1];
  logic [NUM_REGS-1:0]   busy_vec;

  logic write_eff;
  logic mark_eff;
  logic cnt_inc;
  logic cnt_dec;

  // Operations addressed to register 0 are dropped here once, so nothing
  // downstream ever sees them.
  assign write_eff = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0);
  assign mark_eff  = bus.ctrl_markBusy    && (bus.ctrl_busyReg  != '0);

  assign rd_view[0] = '0;
  assign busy_vec   = {busy_reg, 1'b0};

  // -------------------------------------------------------------------------
  // Per-register next state
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic write_hit;
      logic mark_hit;

      assign write_hit = write_eff && (bus.ctrl_writeReg == IDX);
      assign mark_hit  = mark_eff  && (bus.ctrl_busyReg  == IDX);

      assign regs_next[gi] = write_hit ? bus.data_writeReg : regs_reg[gi];
      // A retiring producer clears the bit, but a new producer marking the
      // same register on the same edge keeps it set.
      assign busy_next[gi] = mark_hit | (busy_reg[gi] & ~write_hit);
      assign rd_view[gi]   = regs_reg[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Busy counter: tracks the popcount of busy_reg incrementally.
  //   +1 : mark of a register that is not yet busy
  //   -1 : clear of a busy register not re-marked on the same edge
  // A mark of X together with a clear of Y != X nets to zero.
  // -------------------------------------------------------------------------
  assign cnt_inc = mark_eff && !busy_vec[bus.ctrl_busyReg];
  assign cnt_dec = write_eff && busy_vec[bus.ctrl_writeReg] &&
                   !(mark_eff && (bus.ctrl_busyReg == bus.ctrl_writeReg));

  always_comb begin
    busy_count_next = busy_count_reg;
    if (cnt_inc && !cnt_dec) begin
      busy_count_next = busy_count_reg + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      busy_count_next = busy_count_reg - 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg       <= '0;
      busy_count_reg <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_reg[i] <= regs_next[i];
      end
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
    end
  end

  assign bus.busy_count = busy_count_reg;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [ADDR_W-1:0]     addr;
      logic                  fwd_hit;
      logic [DATA_WIDTH-1:0] rdata;
      logic                  rbusy;

      assign addr = bus.ctrl_readReg[gi*ADDR_W +: ADDR_W];

      // Forwarding only ever fires for a nonzero address, since write_eff
      // already excludes register 0.
      assign fwd_hit = BYPASS && write_eff && (bus.ctrl_writeReg == addr);

      always_comb begin
        rdata = rd_view[addr];
        if (fwd_hit) begin
          rdata = bus.data_writeReg;
        end
        // Stored state is already zero during reset, but the forwarding
        // path is not, so the port is forced to zero explicitly.
        if (!ctrl_reset || (addr == '0)) begin
          rdata = '0;
        end
      end

      // A same-cycle clear releases the stall immediately when forwarding;
      // a same-cycle mark only becomes visible after the edge.
      assign rbusy = busy_vec[addr] && !fwd_hit;

      assign bus.data_readReg[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
      assign bus.read_busy[gi]                              = rbusy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus and
//   compares both against a behavioural model of the register file and
//   scoreboard (plain arrays updated per clock edge).
// ---------------------------------------------------------------------------
module tb_regfile_sb;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic clock;
  logic ctrl_reset;

  logic              we;
  logic [AW-1:0]     wreg;
  logic [DW-1:0]     wdata;
  logic [NRD*AW-1:0] raddr;
  logic              mark;
  logic [AW-1:0]     breg;

  int n_chk;
  int n_pass;

  // Behavioural model
  logic [DW-1:0] mem_m  [0:NR-1];
  bit            busy_m [0:NR-1];

  regfile_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD)) if_b ();
  regfile_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD)) if_nb ();

  assign if_b.ctrl_writeEnable  = we;
  assign if_b.ctrl_writeReg     = wreg;
  assign if_b.data_writeReg     = wdata;
  assign if_b.ctrl_readReg      = raddr;
  assign if_b.ctrl_markBusy     = mark;
  assign if_b.ctrl_busyReg      = breg;
  assign if_nb.ctrl_writeEnable = we;
  assign if_nb.ctrl_writeReg    = wreg;
  assign if_nb.data_writeReg    = wdata;
  assign if_nb.ctrl_readReg     = raddr;
  assign if_nb.ctrl_markBusy    = mark;
  assign if_nb.ctrl_busyReg     = breg;

  regfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD), .BYPASS(1'b1)) dut_b (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (if_b)
  );

  regfile_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ(NRD), .BYPASS(1'b0)) dut_nb (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (if_nb)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mem_m[r]  = '0;
      busy_m[r] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (ctrl_reset) begin
      if (we && wreg != 0) begin
        mem_m[wreg]  = wdata;
        busy_m[wreg] = 1'b0;
      end
      if (mark && breg != 0) busy_m[breg] = 1'b1;
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!ctrl_reset || a == 0) return '0;
    if (byp && we && wreg == a) return wdata;
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (!ctrl_reset || a == 0) return 1'b0;
    if (byp && we && wreg == a) return 1'b0;
    return busy_m[a];
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int r = 1; r < NR; r++) c += int'(busy_m[r]);
    return c;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_raddr(input int p, input logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    we   = 1'b0;
    mark = 1'b0;
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    for (int p = 0; p < NRD; p++) begin
      a = raddr[p*AW +: AW];
      check($sformatf("b_rd%0d_r%0d", p, a),  if_b.data_readReg[p*DW +: DW],  exp_rd(a, 1'b1));
      check($sformatf("nb_rd%0d_r%0d", p, a), if_nb.data_readReg[p*DW +: DW], exp_rd(a, 1'b0));
      check($sformatf("b_busy%0d_r%0d", p, a),  if_b.read_busy[p],  exp_busy(a, 1'b1));
      check($sformatf("nb_busy%0d_r%0d", p, a), if_nb.read_busy[p], exp_busy(a, 1'b0));
    end
    check("b_count",  if_b.busy_count,  exp_count());
    check("nb_count", if_nb.busy_count, exp_count());
  endtask

  // Called at posedge+1: check combinational outputs, take one edge, update model.
  task automatic step();
    #2 check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    we    = ($urandom_range(0, 3) != 0);
    wreg  = AW'($urandom_range(0, NR - 1));
    wdata = $urandom;
    mark  = ($urandom_range(0, 2) == 0);
    breg  = AW'($urandom_range(0, NR - 1));
    for (int p = 0; p < NRD; p++) begin
      if ($urandom_range(0, 2) == 0) set_raddr(p, wreg);
      else set_raddr(p, AW'($urandom_range(0, NR - 1)));
    end
  endtask

  // Reset pulse between edges (called at posedge+1).
  task automatic pulse_reset();
    #2 ctrl_reset = 1'b0;
    model_reset();
    #1 check_all();
    #1 ctrl_reset = 1'b1;
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    ctrl_reset = 1'b0;
    model_reset();
    idle();
    wreg = '0; wdata = '0; breg = '0; raddr = '0;

    // Reset held with random inputs, including bypass-capable writes.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      step();
    end
    check("rst_count", if_b.busy_count, 0);
    ctrl_reset = 1'b1;

    // Writes to r0 are dropped.
    we = 1'b1; wreg = '0; wdata = 32'hDEADBEEF; mark = 1'b1; breg = '0;
    set_raddr(0, 0); set_raddr(1, 0);
    step();
    idle(); #1;
    check("r0_rd0", if_b.data_readReg[0 +: DW], 0);
    check("r0_rd1", if_nb.data_readReg[DW +: DW], 0);
    check("r0_busy", if_b.read_busy, 0);
    check("r0_count", if_b.busy_count, 0);

    // Write r5 with port 0 reading it.
    we = 1'b1; wreg = 5; wdata = 32'h12345678; set_raddr(0, 5);
    #1;
    check("byp_same", if_b.data_readReg[0 +: DW], 32'h12345678);
    check("nobyp_same", if_nb.data_readReg[0 +: DW], 0);
    step();
    idle(); #1;
    check("nobyp_next", if_nb.data_readReg[0 +: DW], 32'h12345678);

    // Scoreboard lifecycle on r7.
    mark = 1'b1; breg = 7;
    step();
    idle(); set_raddr(0, 7); #1;
    check("r7_busy_b", if_b.read_busy[0], 1);
    check("r7_busy_nb", if_nb.read_busy[0], 1);
    check("r7_count", if_b.busy_count, 1);
    we = 1'b1; wreg = 7; wdata = 32'hA5; #1;
    check("r7_clr_b", if_b.read_busy[0], 0);
    check("r7_clr_nb", if_nb.read_busy[0], 1);
    step();
    idle(); #1;
    check("r7_count0", if_nb.busy_count, 0);

    // Mark and write the same busy register.
    mark = 1'b1; breg = 3;
    step();
    mark = 1'b1; breg = 3; we = 1'b1; wreg = 3; wdata = 32'h55;
    step();
    idle(); set_raddr(0, 3); #1;
    check("r3_data", if_nb.data_readReg[0 +: DW], 32'h55);
    check("r3_busy", if_b.read_busy[0], 1);
    check("r3_count", if_b.busy_count, 1);

    // Mark r9 while clearing r3.
    mark = 1'b1; breg = 9; we = 1'b1; wreg = 3; wdata = 32'h66;
    step();
    idle(); set_raddr(0, 3); set_raddr(1, 9); #1;
    check("x_count", if_b.busy_count, 1);
    check("x_r3", if_b.read_busy[0], 0);
    check("x_r9", if_nb.read_busy[1], 1);

    // Saturation.
    pulse_reset();
    for (int r = 1; r < NR; r++) begin
      mark = 1'b1; breg = AW'(r);
      step();
    end
    idle(); #1;
    check("sat_31", if_b.busy_count, 31);
    mark = 1'b1; breg = 4;
    step();
    idle(); #1;
    check("sat_remark", if_nb.busy_count, 31);
    mark = 1'b1; breg = 0;
    step();
    idle(); #1;
    check("sat_r0", if_b.busy_count, 31);

    // Async reset mid-flight with 10 busy registers holding data.
    pulse_reset();
    for (int r = 1; r <= 10; r++) begin
      we = 1'b1; wreg = AW'(r); wdata = $urandom | 32'h1;
      mark = 1'b1; breg = AW'(r);
      step();
    end
    idle(); #1;
    check("mid_count10", if_b.busy_count, 10);
    we = 1'b1; wreg = 2; wdata = 32'hCAFE; set_raddr(0, 2); set_raddr(1, 4);
    #1 ctrl_reset = 1'b0;
    model_reset();
    #1;
    check("mid_rd_b", if_b.data_readReg[0 +: DW], 0);
    check("mid_rd_nb", if_nb.data_readReg[DW +: DW], 0);
    check("mid_busy", if_b.read_busy, 0);
    check("mid_count", if_nb.busy_count, 0);
    #1 ctrl_reset = 1'b1;
    idle();
    for (int r = 0; r < NR; r += 2) begin
      set_raddr(0, AW'(r)); set_raddr(1, AW'(r + 1));
      step();
    end
    check("post_rd", if_nb.data_readReg[0 +: DW], 0);

    // Randomised traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the processor's register file: NUM_REGS × DATA_WIDTH storage with NUM_READ combinational read ports, one write port, and register 0 hardwired to zero. It adds optional write-to-read bypass and a per-register busy scoreboard. The scoreboard lets the decode stage stall on registers owned by in-flight multi-cycle operations (mult/div, loads). It sits between decode (reads, busy marking) and writeback (writes, busy clearing).

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, register count; power of two, ≥ 2; ADDR_W = $clog2(NUM_REGS)
- NUM_READ, 2, number of read ports, ≥ 1
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads show array contents only
- clock  input  1  sole clock, rising edge
- ctrl_reset  input  1  asynchronous, active-low reset
- ctrl_writeEnable  input  1  write strobe
- ctrl_writeReg  input  ADDR_W  write address
- data_writeReg  input  DATA_WIDTH  write data
- ctrl_readReg  input  NUM_READ*ADDR_W  read addresses; port i in bits [i*ADDR_W +: ADDR_W]
- data_readReg  output  NUM_READ*DATA_WIDTH  read data; port i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- read_busy  output  NUM_READ  port i addresses a register with a pending write
- ctrl_markBusy  input  1  mark ctrl_busyReg as pending
- ctrl_busyReg  input  ADDR_W  register to mark busy
- busy_count  output  ADDR_W+1  number of registers currently busy

## Operation
- Storage covers registers 1..NUM_REGS-1. Register 0 has no storage and always reads 0. Register 0 is never busy. Writes and marks to register 0 are ignored.
- Write: on a rising clock edge with ctrl_writeEnable=1 and ctrl_writeReg≠0, the register loads data_writeReg. The same edge clears that register's busy bit.
- Mark: on a rising clock edge with ctrl_markBusy=1 and ctrl_busyReg≠0, the busy bit is set.
- Mark and write to the same register on the same edge: the busy bit ends set (mark wins) and the data is written. This models a new producer issuing as the old one retires.
- Mark to an already-busy register: no change; busy_count is unchanged.
- Write to a non-busy register: data is written; busy_count is unchanged.
- Read port i is combinational:
  - if address = 0, the port returns 0;
  - else, if BYPASS=1, ctrl_writeEnable=1 and ctrl_writeReg = address, the port returns data_writeReg;
  - otherwise the port returns the stored value.
- read_busy[i] = busy[address] AND NOT (ctrl_writeEnable AND ctrl_writeReg = address).
  - The clear masking applies only when BYPASS=1.
  - When BYPASS=0, read_busy[i] = busy[address].
  - A same-cycle mark does not affect read_busy until after the edge.
- busy_count is a registered counter and always equals the popcount of the busy bits.
  - Per edge it changes by +1 (effective mark of a non-busy register), −1 (effective clear with no mark to the same register), or 0.
  - Mark of register X and clear of a different register Y on the same edge nets to 0.
  - The counter never wraps; its maximum is NUM_REGS-1.
- Multiple read ports may address the same register; each port returns identical data and busy.

## Timing
- Reset (ctrl_reset=0, asynchronous): all registers 0, all busy bits 0, busy_count 0. This takes effect immediately, independent of clock.
- While reset is held, the outputs are: data_readReg = 0 on every port (BYPASS path included), read_busy = 0, busy_count = 0.
- Edges while in reset: writes and marks are ignored.
- Reset deassertion: state is held until the first rising edge after release.
- Write latency: 1 edge to storage. 0 cycles to readers when BYPASS=1; 1 cycle when BYPASS=0.
- Mark latency: read_busy and busy_count reflect a mark the cycle after the edge.
- Reset asserted mid-operation (busy bits set): all pending state is discarded and nothing is retained.

## Test plan
- **Reset and zero register:** assert ctrl_reset=0 with random inputs, then release. Write 0xDEADBEEF to r0 and read r0 on all ports → 0, read_busy=0, busy_count=0.
- **Write/read with bypass:** BYPASS=1. In one cycle write 0x12345678 to r5 with port 0 reading r5 → port 0 shows 0x12345678 in the same cycle. Repeat with BYPASS=0 → port 0 shows 0 in that cycle and 0x12345678 in the next.
- **Scoreboard lifecycle:** mark r7 → next cycle read_busy=1, busy_count=1. Write r7 = 0xA5 → read_busy=0 in the write cycle (BYPASS=1), busy_count=0 after the edge.
- **Simultaneous events:**
  - With r3 busy, mark r3 and write r3=0x55 on the same edge → r3=0x55, still busy, busy_count=1.
  - With r3 busy, mark r9 and write r3 on the same edge → busy_count stays 1, r9 busy, r3 clear.
- **Saturation:** mark r1..r31 on consecutive cycles → busy_count=31. Re-mark r4 → still 31. Mark r0 → still 31.
- **Async reset mid-flight:** with 10 busy registers and stored data, pulse ctrl_reset low between edges → outputs 0 immediately. After release, all reads are 0 and busy_count=0.
